// File: rtl/comp_32_bs.sv
// comp_32_bs: registered WIDTH-bit magnitude comparator, signed or unsigned
// mode chosen per cycle by `sign`.
//
// Outputs are the four flags eq/neq/grt/lss. Each is registered and cleared
// asynchronously by resetn. The all-zero flag state appears only in reset.
// After the first edge that follows reset release, exactly one of
// {eq, grt, lss} is set, and eq ^ neq == 1.
//
// Optional build macro COMP_32_BS_INREG_EN adds an input register stage on
// sign/op1/op2. This raises latency from 1 to 2 cycles.
//
// The combinational nets `less` and `equal` live in module scope under these
// exact names. Bound checkers reach them by hierarchical name, so do not
// rename them.
module comp_32_bs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sign,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             eq,
  output logic             neq,
  output logic             grt,
  output logic             lss
);

  // Operands as seen by the compare logic. These are either the raw inputs
  // or their registered copies.
  logic             sign_c;
  logic [WIDTH-1:0] op1_c;
  logic [WIDTH-1:0] op2_c;

`ifdef COMP_32_BS_INREG_EN
  logic             sign_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;

  // Input capture stage; cleared with the rest of the block so nothing survives reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sign_q <= 1'b0;
      op1_q  <= '0;
      op2_q  <= '0;
    end else begin
      sign_q <= sign;
      op1_q  <= op1;
      op2_q  <= op2;
    end
  end

  assign sign_c = sign_q;
  assign op1_c  = op1_q;
  assign op2_c  = op2_q;
`else
  assign sign_c = sign;
  assign op1_c  = op1;
  assign op2_c  = op2;
`endif

  // Widened operands. The extra top bit is a copy of the MSB in signed mode
  // and zero in unsigned mode. This makes one WIDTH+1 subtraction serve both
  // modes.
  logic [WIDTH:0] ext1;
  logic [WIDTH:0] ext2;
  logic [WIDTH:0] diff;
  logic           less;
  logic           equal;

  assign ext1  = {sign_c & op1_c[WIDTH-1], op1_c};
  assign ext2  = {sign_c & op2_c[WIDTH-1], op2_c};
  assign diff  = ext1 - ext2;

  // The top bit of the widened difference is the borrow, i.e. op1 < op2.
  assign less  = diff[WIDTH];
  assign equal = (op1_c == op2_c);

  // Only the sign of the difference matters. Fold the low bits into a sink
  // so they are visibly intentional.
  logic unused_diff_low;
  assign unused_diff_low = ^diff[WIDTH-1:0];

  // Flag register. grt is derived, so it can never coexist with eq or lss.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      eq  <= 1'b0;
      neq <= 1'b0;
      grt <= 1'b0;
      lss <= 1'b0;
    end else begin
      eq  <= equal;
      neq <= ~equal;
      lss <= less;
      grt <= ~less & ~equal;
    end
  end

endmodule

// File: tb/tb_comp_32_bs.sv
// Self-checking bench for comp_32_bs (default build, 1-cycle latency).
//
// Inputs change on the falling edge. The DUT samples them on the next rising
// edge, and the flags are compared on the falling edge after that. Expected
// flags come from a $signed/unsigned relational model, not from subtraction.
module tb_comp_32_bs;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         sign = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         eq, neq, grt, lss;

  // Expected {eq, neq, grt, lss}, queued when stimulus is driven
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Clock: 20 time-unit period
  always #10 clk = ~clk;

  comp_32_bs #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sign   (sign),
    .op1    (op1),
    .op2    (op2),
    .eq     (eq),
    .neq    (neq),
    .grt    (grt),
    .lss    (lss)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic gt, lt;
    if (s) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return {a == b, a != b, gt, lt};
  endfunction

  // Pop one expectation and compare it against the current flags. Also check
  // the one-hot and eq/neq invariants.
  task automatic compare_out(input string tag);
    logic [3:0] e;
    logic       inv;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {28'd0, eq, neq, grt, lss}, {28'd0, e});
    end
    inv = (eq ^ neq) && (({2'b0, eq} + {2'b0, grt} + {2'b0, lss}) == 3'd1);
    check({tag, "_inv"}, {31'd0, inv}, 32'd1);
  endtask

  // Called at a falling edge. Drives one vector and checks it one cycle later.
  task automatic step(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    sign = s;
    op1  = a;
    op2  = b;
    exp_q.push_back(model(s, a, b));
    @(negedge clk);
    compare_out(tag);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;

    // 1: reset hold across two edges, then release
    sign = 1'b0; op1 = 32'd5; op2 = 32'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold", {28'd0, eq, neq, grt, lss}, 32'd0);
    end
    resetn = 1'b1;
    step("t1_eq", 1'b0, 32'd5, 32'd5);

    // 2: all-ones vs one in both modes
    step("t2_uns", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    step("t2_sgn", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);

    // 3: min-negative vs max-positive, then equal operands in both modes
    step("t3_sgn", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
    step("t3_uns", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
    step("t3_eq_s", 1'b1, 32'h8000_0000, 32'h8000_0000);
    step("t3_eq_u", 1'b0, 32'h8000_0000, 32'h8000_0000);
    step("bnd_m1_s", 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    step("bnd_m1_u", 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);

    // 4: back-to-back stream
    step("t4_grt", 1'b1, 32'd3, -32'sd3);
    step("t4_lss", 1'b1, -32'sd7, -32'sd2);
    step("t4_eq", 1'b0, 32'd0, 32'd0);

    // 5: asynchronous reset mid-cycle while grt is set
    step("t5_grt", 1'b1, 32'd3, -32'sd3);
    #2 resetn = 1'b0;
    #1 check("t5_async", {28'd0, eq, neq, grt, lss}, 32'd0);
    #9 resetn = 1'b1;
    @(negedge clk);
    check("t5_post", {28'd0, eq, neq, grt, lss}, 32'd0);
    step("t5_reload", 1'b1, 32'd3, -32'sd3);

    // 6: random sweep with occasional corner values and equal pairs
    for (int i = 0; i < 1200; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = 32'h8000_0000;
        2: b = 32'h7FFF_FFFF;
        3: a = {16'd0, a[15:0]} ^ {b[31:16], 16'd0};
        default: ;
      endcase
      step("rand", s, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_32_bs.md
Name: comp_32_bs

Overview:
- Registered 32-bit magnitude comparator with a runtime-selectable signed or unsigned mode.
- Each clock it compares op1 against op2 and registers four flags: equal, not-equal, greater, less.
- It is a leaf datapath block, driven by a single interface bundle (clk, resetn, sign, op1, op2 in; eq, neq, grt, lss out).
- Internal combinational nets `less` and `equal` are part of the contract: assertion checkers bind to them by hierarchical name.

Parameters:
- WIDTH, 32, operand width in bits. Must be ≥ 2. All widths below scale with it.

Ports:
- clk  input  1  rising-edge clock; only clock domain.
- resetn  input  1  reset, asynchronous, active-low.
- sign  input  1  1 = two's-complement compare; 0 = unsigned compare.
- op1  input  WIDTH  left operand.
- op2  input  WIDTH  right operand.
- eq  output  1  registered: op1 == op2.
- neq  output  1  registered: op1 != op2.
- grt  output  1  registered: op1 > op2 under the selected mode.
- lss  output  1  registered: op1 < op2 under the selected mode.

Behaviour:
- Internal net `equal` (combinational): (op1 == op2). Bit-exact, independent of sign.
- Internal net `less` (combinational), computed by widened subtraction:
  - Extend each operand to WIDTH+1 bits; the extension bit is the operand MSB when sign=1, else 0.
  - diff = ext(op1) - ext(op2).
  - less = diff[WIDTH].
- Net names `less` and `equal` are fixed and must be visible in the module scope for bind-based checkers.
- Registered outputs, updated on every posedge clk while resetn=1:
  - eq <= equal
  - neq <= ~equal
  - lss <= less
  - grt <= ~less & ~equal
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N. No handshake; a new compare every cycle.
- Reset:
  - resetn=0 clears eq, neq, grt and lss to 0 immediately, asynchronously, regardless of clk.
  - The all-zero output state is unique to reset and never produced in normal operation.
- Invariants after the first clock edge following reset release:
  - eq ^ neq == 1.
  - Exactly one of {eq, grt, lss} is 1.
- Reset mid-operation: outputs drop to 0 within the same timestep as resetn falling. The first posedge with resetn=1 reloads from the current inputs. No state survives reset.
- Boundaries:
  - 0x80000000 vs 0x7FFFFFFF: lss when sign=1, grt when sign=0.
  - 0xFFFFFFFF vs 0x00000000: lss when sign=1 (−1 < 0), grt when sign=0.
  - Equal operands give eq regardless of sign.
- Changing sign between cycles takes effect at the next edge, same as an operand change.
- X on inputs: no special handling required.

Optional Feature:
- Macro: COMP_32_BS_INREG_EN.
- Defined: adds an input register stage.
  - sign, op1 and op2 are captured on posedge clk into registers that reset asynchronously to 0.
  - `less` and `equal` are computed from the registered copies.
  - Total latency becomes 2 cycles.
  - Outputs still reset to 0.
  - The first valid flags appear 2 edges after reset release.
- Not defined: no input registers; latency 1 cycle as specified above.
- Test Plan latencies assume the macro is not defined.

Test Plan:
1. Hold resetn=0 across 2 edges; sign=0, op1=5, op2=5 → eq=neq=grt=lss=0 throughout. Release → next edge: eq=1, neq=0, grt=0, lss=0.
2. sign=0, op1=0xFFFFFFFF, op2=0x00000001 → after 1 edge: grt=1, neq=1, eq=0, lss=0. Same operands with sign=1 → lss=1, neq=1, grt=0, eq=0.
3. op1=0x80000000, op2=0x7FFFFFFF → sign=1: lss=1; sign=0: grt=1. Then op1=op2=0x80000000 → eq=1 in both modes.
4. Back-to-back stream over consecutive edges:
   - (sign=1, 3 vs −3) → grt
   - (sign=1, −7 vs −2) → lss
   - (sign=0, 0 vs 0) → eq
   - Outputs track each input pair exactly 1 cycle later with no bubbles.
5. While grt=1, drive resetn=0 mid-cycle for 10 time units → all outputs go 0 immediately, before any clk edge. First edge after release reflects the current inputs.
6. Random sweep of ≥1000 vectors, both sign values → flags match $signed/unsigned reference comparison with 1-cycle delay; one-hot and eq/neq invariants hold every cycle.
